// File: rtl/plic_pkg.sv
// Shared constants and types for the platform-level interrupt controller.
package plic_pkg;
   localparam int N_SRC_DEF  = 8;
   localparam int PRIO_W_DEF = 3;

   localparam logic [21:0] PRIO_BASE   = 22'h000000;
   localparam logic [21:0] PENDING_OFF = 22'h001000;
   localparam logic [21:0] ENABLE_OFF  = 22'h002000;
   localparam logic [21:0] THRESH_OFF  = 22'h200000;
   localparam logic [21:0] CLAIM_OFF   = 22'h200004;

   typedef logic [PRIO_W_DEF-1:0] prio_t;
endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: input synchronizer plus pending and in-flight flops.
module plic_gateway #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic src,
   input  logic claim_hit,
   input  logic complete_hit,
   output logic pending
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   inflight;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= src;
         for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
      end
   end

   // A claim beats a same-cycle set; inflight then blocks re-pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         inflight <= 1'b0;
      end else begin
         if (claim_hit)
            pending <= 1'b0;
         else if (sync_q[SYNC_STAGES-1] && !inflight)
            pending <= 1'b1;

         if (claim_hit)
            inflight <= 1'b1;
         else if (complete_hit)
            inflight <= 1'b0;
      end
   end
endmodule

// File: rtl/plic_core.sv
// Single-context PLIC: register file, arbitration, bus decode, irq_ext flop.
module plic_core
   import plic_pkg::*;
#(
   parameter int N_SRC       = N_SRC_DEF,
   parameter int PRIO_W      = PRIO_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             req,
   input  logic             we,
   input  logic [21:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             ack,
   output logic             irq_ext
);
   localparam int ID_W = $clog2(N_SRC + 1);

   logic [PRIO_W-1:0] prio_q [1:N_SRC];
   logic [N_SRC:1]    enable_q;
   logic [PRIO_W-1:0] thresh_q;
   logic [N_SRC:1]    pend;
   logic [N_SRC:1]    claim_hit;
   logic [N_SRC:1]    complete_hit;
   logic [PRIO_W-1:0] best;
   logic [ID_W-1:0]   win_id;
   logic [9:0]        prio_idx;
   logic [31:0]       rd_mux;
   logic              rd, wr;
   logic              sel_prio, sel_pend, sel_en, sel_thr, sel_claim;

   assign rd        = req && !we;
   assign wr        = req && we;
   assign prio_idx  = addr[11:2];
   assign sel_prio  = (addr[21:12] == PRIO_BASE[21:12]) && (addr[1:0] == 2'b00);
   assign sel_pend  = (addr == PENDING_OFF);
   assign sel_en    = (addr == ENABLE_OFF);
   assign sel_thr   = (addr == THRESH_OFF);
   assign sel_claim = (addr == CLAIM_OFF);

   // Starting from the threshold makes "> threshold" and "> best" one test.
   always_comb begin
      best   = thresh_q;
      win_id = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         if (pend[i] && enable_q[i] && prio_q[i] > best) begin
            best   = prio_q[i];
            win_id = ID_W'(i);
         end
      end
   end

   for (genvar g = 1; g <= N_SRC; g++) begin : g_gw
      assign claim_hit[g]    = rd && sel_claim && (win_id == ID_W'(g));
      assign complete_hit[g] = wr && sel_claim && (wdata == 32'(g));

      plic_gateway #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_gw (
         .clk          (clk),
         .rst_n        (rst_n),
         .src          (irq_src[g-1]),
         .claim_hit    (claim_hit[g]),
         .complete_hit (complete_hit[g]),
         .pending      (pend[g])
      );
   end

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         sel_prio: begin
            for (int i = 1; i <= N_SRC; i++)
               if (prio_idx == 10'(i))
                  rd_mux = 32'(prio_q[i]);
         end
         sel_pend:  rd_mux = 32'({pend, 1'b0});
         sel_en:    rd_mux = 32'({enable_q, 1'b0});
         sel_thr:   rd_mux = 32'(thresh_q);
         sel_claim: rd_mux = 32'(win_id);
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= N_SRC; i++)
            prio_q[i] <= '0;
         enable_q <= '0;
         thresh_q <= '0;
      end else if (wr) begin
         if (sel_prio)
            for (int i = 1; i <= N_SRC; i++)
               if (prio_idx == 10'(i))
                  prio_q[i] <= wdata[PRIO_W-1:0];
         if (sel_en)
            enable_q <= wdata[N_SRC:1];
         if (sel_thr)
            thresh_q <= wdata[PRIO_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack     <= 1'b0;
         rdata   <= '0;
         irq_ext <= 1'b0;
      end else begin
         ack     <= req;
         rdata   <= rd ? rd_mux : '0;
         irq_ext <= (win_id != '0);
      end
   end
endmodule

// File: doc/plic_core.md
Name: plic_core

Overview:
- Platform-level interrupt controller for the single rv_core hart (machine context 0).
- Sits on the D-bus as a slave and aggregates GPIO and peripheral interrupt lines.
- Drives irq_ext into core0; it is the block that feeds the core's external-interrupt input.
- A thin plic_wrapped adapts slave_bus_if to the flat register port below, matching the gpio_wrapped arrangement.

Parameters:
- N_SRC, 8: number of interrupt sources, IDs 1..N_SRC; ID 0 is reserved, meaning "none".
- PRIO_W, 3: priority width. Priority 0 means never interrupt.
- SYNC_STAGES, 2: synchronizer flops per source input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_src  in  N_SRC  level-high interrupt requests; bit i-1 is source ID i; asynchronous to clk
- req  in  1  register access strobe, one cycle per access
- we  in  1  1 = write, 0 = read
- addr  in  22  byte offset within the PLIC window, word-aligned
- wdata  in  32  write data
- rdata  out  32  read data, valid while ack=1
- ack  out  1  access complete
- irq_ext  out  1  external interrupt to the core

Behaviour:
- Reset (asynchronous, rst_n=0) clears everything: priorities, enables, threshold, pending, in-flight, synchronizers, rdata, ack, irq_ext.
- Register map (byte offsets):
  - 0x000000+4*i: priority[i], i = 1..N_SRC, read/write, bits [PRIO_W-1:0]. Offset 0x000000 reads 0.
  - 0x001000: pending, read-only; bit i = source i; bit 0 is always 0.
  - 0x002000: enable, read/write; bit 0 is forced to 0.
  - 0x200000: threshold, read/write, bits [PRIO_W-1:0].
  - 0x200004: claim/complete. A read claims; a write completes.
- Unmapped offsets read 0, writes are ignored, and ack is still returned.
- Bus handshake:
  - ack is registered and pulses exactly 1 cycle after req.
  - rdata is registered with ack.
  - req must not be reasserted while ack=1; the master guarantees this.
- Gateway, per source:
  - sync = irq_src after SYNC_STAGES flops.
  - pending[i] sets on the cycle after sync[i]=1 && !pending[i] && !inflight[i].
- Claim (read of 0x200004):
  - Returns the winner ID, evaluated combinationally in the req cycle.
  - Winner = enabled, pending source with priority > threshold and the highest priority. Ties go to the lowest ID.
  - On claim: pending[winner] is cleared and inflight[winner] is set.
  - If there is no winner, returns 0 and no state changes.
- Complete (write of ID to 0x200004):
  - If 1 ≤ ID ≤ N_SRC and inflight[ID]=1, inflight[ID] is cleared.
  - Otherwise the write is ignored.
  - If the level is still high, the source re-pends the next cycle.
- irq_ext:
  - Registered; equals 1 iff a winner exists.
  - Latency from irq_src rising to irq_ext=1 is SYNC_STAGES+2 edges, i.e. 4 by default.
  - irq_ext deasserts 1 cycle after the claim, or after a threshold, priority or enable change removes the winner.
- Simultaneous events:
  - A claim and a gateway set on the same source in the same cycle: the claim wins and inflight blocks re-pending.
  - A source that drops before it is claimed stays pending (latched).
  - Writes to the pending register are ignored.
- Disabled sources still latch pending; enable only gates arbitration.

Decomposition:
- plic_pkg:
  - Register offset localparams: PRIO_BASE, PENDING_OFF, ENABLE_OFF, THRESH_OFF, CLAIM_OFF.
  - Defaults for N_SRC and PRIO_W.
  - prio_t typedef.
- Sub-module plic_gateway, instantiated N_SRC times:
  - Contains the synchronizer, the pending flop and the inflight flop.
  - Inputs: claim_hit, complete_hit.
  - Output: pending.
- plic_core holds:
  - the register file;
  - an arbitration loop (lowest-ID-first, strict >);
  - bus decode;
  - the irq_ext flop.

Test Plan:
- Reset and defaults: after reset, every register reads 0. A claim read returns 0. irq_src=8'hFF with enable=0 gives irq_ext=0, while pending reads 0x1FE.
- Basic flow:
  - Setup: priority[3]=2, enable=0x08, threshold=0.
  - Raise irq_src[2]; irq_ext rises 4 edges later.
  - Claim returns 3 and irq_ext falls next cycle.
  - Complete writing 3 with the source still high: pending[3] re-sets and irq_ext reasserts.
- Priority and tie-break:
  - Setup: priority[2]=5, [5]=5, [7]=6; all enabled; all raised.
  - Successive claims return 7, 2, 5, then 0.
- Threshold: priority[4]=3. threshold=3 gives irq_ext=0; writing threshold=2 gives irq_ext=1 next cycle.
- Bad complete: writing 0, 9, or an ID that is not in flight leaves inflight unchanged, and the source stays blocked.
- Reset mid-operation: source 6 in flight and pending bits set, then assert rst_n=0 asynchronously mid-cycle. All state clears immediately and irq_ext=0 without waiting for a clock edge.
